// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: instruction-in / control-word-out handshake bundle.
// master = upstream+execute side, slave = alu_ctrl_seq.
interface alu_ctrl_seq_if #(
  parameter int FIFO_DEPTH = 2
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          in_valid;
  logic          in_ready;
  logic          in_jump;
  logic [4:0]    in_opcode;
  logic [1:0]    in_funct;
  logic          out_valid;
  logic          out_ready;
  logic [6:0]    out_ctrl;
  logic          out_cond;
  logic          out_carry_chain;
  logic          out_last;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_jump, in_opcode, in_funct, out_ready,
    input  in_ready, out_valid, out_ctrl, out_cond,
    input  out_carry_chain, out_last, count
  );

  modport slave (
    input  in_valid, in_jump, in_opcode, in_funct, out_ready,
    output in_ready, out_valid, out_ctrl, out_cond,
    output out_carry_chain, out_last, count
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decode, PASSES-slice expansion,
// FIFO_DEPTH control queue. Ports: clk, rst_n, bus (alu_ctrl_seq_if.slave),
// flush only when ALU_CTRL_FLUSH_EN is defined.
module alu_ctrl_seq #(
  parameter int PASSES     = 1,
  parameter int FIFO_DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
`ifdef ALU_CTRL_FLUSH_EN
  input logic flush,
`endif
  alu_ctrl_seq_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [2:0] op;
    logic       inv_a;
    logic       inv_b;
    logic       sign;
    logic       cin;
    logic       cond;
  } dec_t;

  typedef struct packed {
    logic       last;
    logic       chain;
    logic       cond;
    logic [6:0] ctrl;
  } word_t;

  typedef enum logic {IDLE, EXPAND} state_t;

  function automatic dec_t decode(
    input logic [4:0] opc,
    input logic [1:0] fn,
    input logic       jmp
  );
    dec_t       d;
    logic [2:0] op;
    logic       cond;
    logic       sub;
    cond = opc[4:2] == 3'b111;
    if (jmp || (cond && opc[1:0] == 2'b11))
      op = 3'b100;
    else if (cond)
      op = 3'b101;
    else if (opc[4:2] == 3'b100)
      op = 3'b100;
    else if (opc[4:3] == 2'b11)
      op = {opc[0], fn};
    else
      op = {opc[3], opc[1:0]};
    // SUB is ADD of ~A + 1 with signed result.
    sub     = op == 3'b101;
    d.op    = sub ? 3'b100 : op;
    d.inv_a = sub;
    d.sign  = sub;
    d.cin   = sub;
    d.inv_b = d.op == 3'b111;
    d.cond  = cond;
    return d;
  endfunction

  function automatic word_t expand(
    input dec_t       d,
    input logic [1:0] k
  );
    word_t w;
    logic  first;
    logic  last;
    first   = k == 2'd0;
    last    = k == 2'(PASSES - 1);
    w.ctrl  = {d.cin & first, d.sign & last,
               d.inv_b, d.inv_a, d.op};
    w.chain = !first && d.op == 3'b100;
    w.cond  = d.cond & last;
    w.last  = last;
    return w;
  endfunction

  state_t        state;
  logic [1:0]    k;
  dec_t          dec_q;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count_q;
  word_t         mem [FIFO_DEPTH];

  logic  full;
  logic  empty;
  logic  in_ready;
  logic  accept;
  logic  push;
  logic  pop;
  dec_t  dec_now;
  word_t wdata;
  word_t head;

  always_comb begin
    full     = count_q == CW'(FIFO_DEPTH);
    empty    = count_q == '0;
    in_ready = rst_n && state == IDLE && !full;
`ifdef ALU_CTRL_FLUSH_EN
    in_ready = in_ready && !flush;
`endif
    dec_now = decode(bus.in_opcode, bus.in_funct, bus.in_jump);
    accept  = bus.in_valid && in_ready;
    push    = (state == IDLE) ? accept : !full;
    pop     = bus.out_ready && !empty;
`ifdef ALU_CTRL_FLUSH_EN
    if (flush) begin
      push = 1'b0;
      pop  = 1'b0;
    end
`endif
    if (state == IDLE)
      wdata = expand(dec_now, 2'd0);
    else
      wdata = expand(dec_q, k);
    head = empty ? '0 : mem[rptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= 2'd0;
      dec_q   <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
`ifdef ALU_CTRL_FLUSH_EN
    end else if (flush) begin
      state   <= IDLE;
      k       <= 2'd0;
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
`endif
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      unique case (state)
        IDLE: begin
          if (accept) begin
            dec_q <= dec_now;
            if (PASSES > 1) begin
              state <= EXPAND;
              k     <= 2'd1;
            end
          end
        end
        EXPAND: begin
          if (!full) begin
            k <= k + 2'd1;
            if (k == 2'(PASSES - 1)) begin
              state <= IDLE;
              k     <= 2'd0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= wdata;
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = !empty;
  assign bus.out_ctrl        = head.ctrl;
  assign bus.out_cond        = head.cond;
  assign bus.out_carry_chain = head.chain;
  assign bus.out_last        = head.last;
  assign bus.count           = count_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed + randomized checks of alu_ctrl_seq
// with PASSES=1/2/4 instances against a queue-based reference model.
module tb_alu_ctrl_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
`ifdef ALU_CTRL_FLUSH_EN
  logic flush;
`endif

  int vectors = 0;
  int errors  = 0;

  logic [9:0] mq[$];
  logic [9:0] pend[$];

  alu_ctrl_seq_if #(.FIFO_DEPTH(2)) b1();
  alu_ctrl_seq_if #(.FIFO_DEPTH(2)) b2();
  alu_ctrl_seq_if #(.FIFO_DEPTH(4)) b4();

  alu_ctrl_seq #(.PASSES(1), .FIFO_DEPTH(2)) u1 (
    .clk(clk), .rst_n(rst_n),
`ifdef ALU_CTRL_FLUSH_EN
    .flush(flush),
`endif
    .bus(b1));
  alu_ctrl_seq #(.PASSES(2), .FIFO_DEPTH(2)) u2 (
    .clk(clk), .rst_n(rst_n),
`ifdef ALU_CTRL_FLUSH_EN
    .flush(flush),
`endif
    .bus(b2));
  alu_ctrl_seq #(.PASSES(4), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n),
`ifdef ALU_CTRL_FLUSH_EN
    .flush(flush),
`endif
    .bus(b4));

  // Expected {last, carry_chain, cond, ctrl} for pass k of P.
  function automatic logic [9:0] ref_word(
    input logic [4:0] opc, input logic [1:0] fn,
    input logic jp, input int k, input int P);
    int op;
    int ctrl;
    bit sub, cond, last;
    cond = opc[4:2] == 3'b111;
    if (jp || (cond && opc[1:0] == 2'b11) || opc[4:2] == 3'b100)
      op = 4;
    else if (cond)
      op = 5;
    else if (opc[4:3] == 2'b11)
      op = 4 * int'(opc[0]) + int'(fn);
    else
      op = 4 * int'(opc[3]) + int'(opc[1:0]);
    sub = op == 5;
    if (sub) op = 4;
    last = k == P - 1;
    ctrl = op + (sub ? 8 : 0) + (op == 7 ? 16 : 0)
         + ((sub && last) ? 32 : 0) + ((sub && k == 0) ? 64 : 0);
    return {last, (k > 0 && op == 4), (cond && last), 7'(ctrl)};
  endfunction

  task automatic drive(input int sel, input logic v,
    input logic [4:0] opc, input logic [1:0] fn,
    input logic jp, input logic ordy);
    case (sel)
      1: begin
        b1.in_valid = v; b1.in_opcode = opc; b1.in_funct = fn;
        b1.in_jump = jp; b1.out_ready = ordy;
      end
      2: begin
        b2.in_valid = v; b2.in_opcode = opc; b2.in_funct = fn;
        b2.in_jump = jp; b2.out_ready = ordy;
      end
      default: begin
        b4.in_valid = v; b4.in_opcode = opc; b4.in_funct = fn;
        b4.in_jump = jp; b4.out_ready = ordy;
      end
    endcase
  endtask

  task automatic sample(input int sel, output logic ir,
    output logic ov, output logic [9:0] w, output int cnt);
    case (sel)
      1: begin
        ir = b1.in_ready; ov = b1.out_valid; cnt = int'(b1.count);
        w = {b1.out_last, b1.out_carry_chain, b1.out_cond, b1.out_ctrl};
      end
      2: begin
        ir = b2.in_ready; ov = b2.out_valid; cnt = int'(b2.count);
        w = {b2.out_last, b2.out_carry_chain, b2.out_cond, b2.out_ctrl};
      end
      default: begin
        ir = b4.in_ready; ov = b4.out_valid; cnt = int'(b4.count);
        w = {b4.out_last, b4.out_carry_chain, b4.out_cond, b4.out_ctrl};
      end
    endcase
  endtask

  task automatic idle_all();
    drive(1, 0, 5'd0, 2'd0, 0, 0);
    drive(2, 0, 5'd0, 2'd0, 0, 0);
    drive(4, 0, 5'd0, 2'd0, 0, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int s[3] = '{1, 2, 4};
    logic ir, ov;
    logic [9:0] w;
    int cnt;
    rst_n = 1'b0;
    idle_all();
    @(negedge clk); #1;
    foreach (s[i]) begin
      sample(s[i], ir, ov, w, cnt);
      vectors++;
      if (ov !== 1'b0 || w !== 10'd0 || cnt != 0) begin
        errors++;
        $display("FAIL reset_state u%0d: valid=%b word=%h count=%0d want 0/000/0",
                 s[i], ov, w, cnt);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    foreach (s[i]) begin
      sample(s[i], ir, ov, w, cnt);
      vectors++;
      if (ir !== 1'b1) begin
        errors++;
        $display("FAIL reset_in_ready u%0d: got %b want 1", s[i], ir);
      end
    end
  endtask

  task automatic test_decode();
    logic [4:0] t_op [9] = '{5'b11011, 5'b11011, 5'b11011, 5'b11110,
      5'b11111, 5'b10001, 5'b01010, 5'b01010, 5'b01011};
    logic [1:0] t_fn [9] = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b00,
      2'b00, 2'b10, 2'b10, 2'b00};
    logic t_jp [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic [9:0] t_w [9] = '{10'h204, 10'h26C, 10'h217, 10'h2EC,
      10'h284, 10'h204, 10'h204, 10'h206, 10'h217};
    logic ir, ov;
    logic [9:0] w, exp_w;
    logic [4:0] opc;
    logic [1:0] fn;
    logic jp;
    int cnt;
    apply_reset();
    for (int i = 0; i < 29; i++) begin
      if (i < 9) begin
        opc = t_op[i]; fn = t_fn[i]; jp = t_jp[i]; exp_w = t_w[i];
      end else begin
        opc = 5'($urandom); fn = 2'($urandom);
        jp = 1'($urandom_range(0, 3) == 0);
        exp_w = ref_word(opc, fn, jp, 0, 1);
      end
      @(negedge clk);
      drive(1, 1, opc, fn, jp, 1);
      #1; sample(1, ir, ov, w, cnt);
      vectors++;
      if (ir !== 1'b1) begin
        errors++;
        $display("FAIL decode_ready[%0d]: got %b want 1", i, ir);
      end
      @(negedge clk);
      drive(1, 0, 5'd0, 2'd0, 0, 1);
      #1; sample(1, ir, ov, w, cnt);
      vectors++;
      if (ov !== 1'b1 || w !== exp_w) begin
        errors++;
        $display("FAIL decode[%0d] op=%b fn=%b j=%b: valid=%b word=%h want 1/%h",
                 i, opc, fn, jp, ov, w, exp_w);
      end
    end
    idle_all();
  endtask

  task automatic test_sub_p2();
    logic ir, ov;
    logic [9:0] w;
    int cnt;
    apply_reset();
    @(negedge clk);
    drive(2, 1, 5'b11011, 2'b01, 0, 1);
    #1; sample(2, ir, ov, w, cnt);
    vectors++;
    if (ir !== 1'b1) begin
      errors++;
      $display("FAIL sub_p2_accept: in_ready=%b want 1", ir);
    end
    @(negedge clk);
    drive(2, 1, 5'b11011, 2'b01, 0, 1);
    #1; sample(2, ir, ov, w, cnt);
    vectors++;
    if (ir !== 1'b0 || ov !== 1'b1 || w !== 10'h04C) begin
      errors++;
      $display("FAIL sub_p2_word1: ready=%b valid=%b word=%h want 0/1/04c",
               ir, ov, w);
    end
    @(negedge clk);
    drive(2, 0, 5'd0, 2'd0, 0, 1);
    #1; sample(2, ir, ov, w, cnt);
    vectors++;
    if (ir !== 1'b1 || ov !== 1'b1 || w !== 10'h32C) begin
      errors++;
      $display("FAIL sub_p2_word2: ready=%b valid=%b word=%h want 1/1/32c",
               ir, ov, w);
    end
    @(negedge clk);
    idle_all();
  endtask

  task automatic test_backpressure();
    logic ir, ov;
    logic [9:0] w;
    int cnt;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1, 1, 5'b11011, 2'b00, 0, 0);
      #1; sample(1, ir, ov, w, cnt);
      vectors++;
      if (ir !== 1'b1 || cnt != i) begin
        errors++;
        $display("FAIL bp_fill[%0d]: ready=%b count=%0d want 1/%0d",
                 i, ir, cnt, i);
      end
    end
    @(negedge clk);
    drive(1, 1, 5'b11011, 2'b00, 0, 1);
    #1; sample(1, ir, ov, w, cnt);
    vectors++;
    if (ir !== 1'b0 || cnt != 2) begin
      errors++;
      $display("FAIL bp_full: ready=%b count=%0d want 0/2", ir, cnt);
    end
    @(negedge clk);
    drive(1, 1, 5'b11011, 2'b00, 0, 0);
    #1; sample(1, ir, ov, w, cnt);
    vectors++;
    if (ir !== 1'b1 || cnt != 1) begin
      errors++;
      $display("FAIL bp_after_pop: ready=%b count=%0d want 1/1", ir, cnt);
    end
    @(negedge clk);
    drive(1, 0, 5'd0, 2'd0, 0, 1);
    #1; sample(1, ir, ov, w, cnt);
    vectors++;
    if (cnt != 2 || w !== 10'h204) begin
      errors++;
      $display("FAIL bp_third: count=%0d word=%h want 2/204", cnt, w);
    end
    repeat (2) @(negedge clk);
    #1; sample(1, ir, ov, w, cnt);
    vectors++;
    if (ov !== 1'b0 || cnt != 0) begin
      errors++;
      $display("FAIL bp_drain: valid=%b count=%0d want 0/0", ov, cnt);
    end
    idle_all();
  endtask

  task automatic test_reset_mid();
    logic ir, ov;
    logic [9:0] w, exp_w;
    int cnt;
    apply_reset();
    @(negedge clk);
    drive(4, 1, 5'b11011, 2'b00, 0, 0);
    @(negedge clk);
    drive(4, 0, 5'd0, 2'd0, 0, 0);
    @(negedge clk);
    #1; sample(4, ir, ov, w, cnt);
    vectors++;
    if (cnt != 2 || ir !== 1'b0) begin
      errors++;
      $display("FAIL rmid_pre: count=%0d ready=%b want 2/0", cnt, ir);
    end
    rst_n = 1'b0;
    #1; sample(4, ir, ov, w, cnt);
    vectors++;
    if (ov !== 1'b0 || w !== 10'd0 || cnt != 0) begin
      errors++;
      $display("FAIL rmid_reset: valid=%b word=%h count=%0d want 0/000/0",
               ov, w, cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(4, 1, 5'b11011, 2'b01, 0, 1);
    #1; sample(4, ir, ov, w, cnt);
    vectors++;
    if (ir !== 1'b1 || ov !== 1'b0) begin
      errors++;
      $display("FAIL rmid_release: ready=%b valid=%b want 1/0", ir, ov);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(4, 0, 5'd0, 2'd0, 0, 1);
      #1; sample(4, ir, ov, w, cnt);
      exp_w = ref_word(5'b11011, 2'b01, 0, k, 4);
      vectors++;
      if (ov !== 1'b1 || w !== exp_w) begin
        errors++;
        $display("FAIL rmid_pass%0d: valid=%b word=%h want 1/%h",
                 k, ov, w, exp_w);
      end
    end
    @(negedge clk);
    idle_all();
  endtask

`ifdef ALU_CTRL_FLUSH_EN
  task automatic test_flush();
    logic ir, ov;
    logic [9:0] w;
    int cnt;
    apply_reset();
    repeat (2) begin
      @(negedge clk);
      drive(1, 1, 5'b11011, 2'b00, 0, 0);
    end
    @(negedge clk);
    flush = 1'b1;
    drive(1, 1, 5'b11011, 2'b00, 0, 1);
    #1; sample(1, ir, ov, w, cnt);
    vectors++;
    if (cnt != 2 || ir !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: count=%0d ready=%b want 2/0", cnt, ir);
    end
    @(negedge clk);
    flush = 1'b0;
    drive(1, 0, 5'd0, 2'd0, 0, 0);
    #1; sample(1, ir, ov, w, cnt);
    vectors++;
    if (cnt != 0 || ov !== 1'b0 || ir !== 1'b1 || w !== 10'd0) begin
      errors++;
      $display("FAIL flush_after: count=%0d valid=%b ready=%b word=%h want 0/0/1/000",
               cnt, ov, ir, w);
    end
  endtask
`endif

  task automatic test_random(input int sel, input int n);
    int P, D, cnt;
    logic ir, ov, v, jp, ordy;
    logic [9:0] w, exp_w;
    logic [4:0] opc;
    logic [1:0] fn;
    bit exp_ir, full;
    P = sel;
    D = (sel == 4) ? 4 : 2;
    apply_reset();
    mq.delete();
    pend.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v = 1'($urandom_range(0, 9) < 6);
      opc = 5'($urandom);
      fn = 2'($urandom);
      jp = 1'($urandom_range(0, 7) == 0);
      ordy = 1'($urandom_range(0, 1));
      drive(sel, v, opc, fn, jp, ordy);
      #1; sample(sel, ir, ov, w, cnt);
      exp_ir = pend.size() == 0 && mq.size() < D;
      exp_w = (mq.size() > 0) ? mq[0] : 10'd0;
      vectors++;
      if (ir !== exp_ir || cnt != mq.size()) begin
        errors++;
        $display("FAIL rand_u%0d[%0d] flow: ready=%b count=%0d want %b/%0d",
                 sel, i, ir, cnt, exp_ir, mq.size());
      end
      vectors++;
      if (ov !== (mq.size() > 0) || w !== exp_w) begin
        errors++;
        $display("FAIL rand_u%0d[%0d] head: valid=%b word=%h want %b/%h",
                 sel, i, ov, w, mq.size() > 0, exp_w);
      end
      full = mq.size() == D;
      if (ordy && mq.size() > 0)
        void'(mq.pop_front());
      if (pend.size() > 0) begin
        if (!full)
          mq.push_back(pend.pop_front());
      end else if (v && exp_ir) begin
        for (int k = 0; k < P; k++) begin
          if (k == 0)
            mq.push_back(ref_word(opc, fn, jp, k, P));
          else
            pend.push_back(ref_word(opc, fn, jp, k, P));
        end
      end
    end
    @(negedge clk);
    idle_all();
  endtask

  initial begin
`ifdef ALU_CTRL_FLUSH_EN
    flush = 1'b0;
`endif
    rst_n = 1'b0;
    idle_all();
    test_reset();
    test_decode();
    test_sub_p2();
    test_backpressure();
    test_reset_mid();
`ifdef ALU_CTRL_FLUSH_EN
    test_flush();
`endif
    test_random(1, 300);
    test_random(2, 300);
    test_random(4, 400);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
